channel_fifo: RTL and testbench
===============================

# channel_fifo

- Parameterized first-word-fall-through FIFO that implements one CSP channel between a producer process and its consumer.
- Sits directly upstream of the 1-to-2 fork arbiter and drives its `channel_read_*` inputs.
- Read side presents head data with `read_valid`; the consumer pops in the same cycle by raising `read_request`.
- Write side accepts a word whenever the FIFO is not full.

## Interface
- `WIDTH`, default 32: data width in bits.
- `DEPTH`, default 4: number of entries; must be a power of two and at least 2.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `write_data` input, WIDTH bits: word offered by the producer.
- `write_request` input, 1 bit: producer offers `write_data` this cycle.
- `write_ready` output, 1 bit: FIFO can accept a word this cycle (not full).
- `read_data` output, WIDTH bits: head word; 0 when `read_valid` is low.
- `read_request` input, 1 bit: consumer pops the head this cycle.
- `read_valid` output, 1 bit: FIFO holds at least one word (not empty).
- `count` output, $clog2(DEPTH+1) bits: current occupancy, 0..DEPTH.

## Operation
- Storage is DEPTH entries, addressed by write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits.
  - Both pointers wrap modulo DEPTH with natural overflow.
  - Occupancy is held in a separate `count` register; full and empty are derived from `count` only.
- Write fires when `write_request && write_ready`.
  - `mem[wr_ptr]` <= `write_data`.
  - `wr_ptr` increments.
- Read fires when `read_request && read_valid`.
  - `rd_ptr` increments.
- `count` update:
  - +1 on write only.
  - −1 on read only.
  - Unchanged when both fire or neither fires.
- `write_request` while full is ignored; no state change, no error flag.
- `read_request` while empty is ignored.
- `write_ready` = (`count` != DEPTH).
  - It depends only on registered state, never on `read_request`.
  - A write while full is refused even if a pop happens in the same cycle. This is deliberate: it avoids a combinational path from the consumer to the producer.
- `read_valid` = (`count` != 0). `read_data` = `mem[rd_ptr]` when `read_valid` is high, else 0.
- No bypass: a word written into an empty FIFO is not visible on the read side in the same cycle.
- Reset clears `wr_ptr`, `rd_ptr` and `count`. Storage contents are not cleared; the zero-masking on `read_data` keeps them unobservable.

## Timing
- Outputs immediately after reset: `write_ready`=1, `read_valid`=0, `read_data`=0, `count`=0.
- Write-to-read latency is 1 cycle: a word accepted at edge N appears on `read_data`, with `read_valid`=1, after edge N.
- Pop takes effect at the edge: `read_data` shows the next word, or 0 if the FIFO is now empty, in the following cycle.
- `read_data`, `read_valid` and `write_ready` are combinational from registers only; there are no input-to-output combinational paths.
- Simultaneous read and write:
  - When 0 < `count` < DEPTH, both fire; `count` is unchanged and pointers advance together.
  - When empty, only the write fires.
  - When full, only the read fires.
- Wrap-around: after DEPTH writes and DEPTH reads, both pointers return to 0; order is preserved across the wrap.
- Reset asserted mid-operation: state is empty at the next edge, in-flight words are discarded, and any request in the reset cycle is ignored.
- Sustained throughput is one word per cycle when neither full nor empty.

## Structure
- Shared channel package holds:
  - `CHANNEL_WIDTH` = 32, used as the default for `WIDTH`.
  - A helper function for the pointer width, $clog2(DEPTH).
  - This package is shared with the fork and any join/merge primitives.
- Sub-module `channel_fifo_mem`:
  - Holds the DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port.
  - It keeps the storage separate from pointer/count control so the array can later be mapped to LUTRAM.
- Control logic (pointers, count, flags, output masking) stays in `channel_fifo`.

## Test plan
- Reset then idle: `write_ready`=1, `read_valid`=0, `read_data`=0, `count`=0. Hold `read_request`=1 for 3 cycles and confirm nothing changes.
- Fill: with DEPTH=4, write 0xA0..0xA3 on consecutive cycles.
  - `count` goes 1,2,3,4; `write_ready`=0 after the 4th write.
  - A 5th write of 0xA4 is dropped.
  - Popping yields 0xA0,0xA1,0xA2,0xA3, then `read_valid`=0.
- Full plus simultaneous read/write: at `count`=4, assert both requests. The read pops 0xA0, the write is refused, and `count`=3. Next cycle, both requests fire and `count` stays 3.
- Empty plus simultaneous read/write: at `count`=0, write 0x55 with `read_request`=1. Nothing is popped; the next cycle shows `read_valid`=1 and `read_data`=0x55.
- Wrap and streaming: write and read 10 words 0x00..0x09 back-to-back at one per cycle with `count` held at 1. Output order matches input order across two pointer wraps.
- Reset mid-operation: with `count`=3, assert `reset` for one cycle alongside `write_request`. After the reset edge, `count`=0, `read_valid`=0 and `read_data`=0, and the write is not stored.

Source files
------------

// File: rtl/channel_fifo_pkg.sv
// channel_fifo_pkg: shared channel constants and pointer-width helper
package channel_fifo_pkg;
  localparam int CHANNEL_WIDTH = 32;
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/channel_fifo_mem.sv
// channel_fifo_mem: DEPTH x WIDTH storage, one sync write port (clk, we, waddr, wdata), one async read port (raddr, rdata)
module channel_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/channel_fifo.sv
// channel_fifo: FWFT CSP channel FIFO; write side (write_data, write_request, write_ready), read side (read_data, read_request, read_valid), occupancy count
module channel_fifo
  import channel_fifo_pkg::*;
#(
  parameter int WIDTH = CHANNEL_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           write_data,
  input  logic                       write_request,
  output logic                       write_ready,
  output logic [WIDTH-1:0]           read_data,
  input  logic                       read_request,
  output logic                       read_valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem_data;
  logic wr_fire, rd_fire;
  // Flags come from count alone so no consumer-to-producer combinational path exists
  assign write_ready = count != CW'(DEPTH);
  assign read_valid = count != '0;
  assign wr_fire = write_request && write_ready;
  assign rd_fire = read_request && read_valid;
  // Stale storage is hidden when empty
  assign read_data = read_valid ? mem_data : '0;
  channel_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(wr_fire && !reset),
    .waddr(wr_ptr),
    .wdata(write_data),
    .raddr(rd_ptr),
    .rdata(mem_data)
  );
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_fire) - CW'(rd_fire);
    end
endmodule

// File: tb/tb_channel_fifo.sv
// tb_channel_fifo: directed self-checking bench for channel_fifo (WIDTH=32, DEPTH=4)
module tb_channel_fifo;
  logic clk = 0;
  logic reset = 1;
  logic [31:0] write_data = '0;
  logic write_request = 0;
  logic write_ready;
  logic [31:0] read_data;
  logic read_request = 0;
  logic read_valid;
  logic [2:0] count;
  int checks = 0;
  int failures = 0;

  channel_fifo #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .write_data(write_data),
    .write_request(write_request),
    .write_ready(write_ready),
    .read_data(read_data),
    .read_request(read_request),
    .read_valid(read_valid),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    step();
    reset = 0;
    checks++; if (write_ready !== 1'b1) begin failures++; $display("FAIL reset_write_ready got=%0b exp=1", write_ready); end
    checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL reset_read_valid got=%0b exp=0", read_valid); end
    checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL reset_read_data got=%0h exp=0", read_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    read_request = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (count !== 3'd0 || read_valid !== 1'b0 || read_data !== 32'h0 || write_ready !== 1'b1)
        begin failures++; $display("FAIL idle_pop cyc=%0d got count=%0d rv=%0b rd=%0h wr=%0b exp 0/0/0/1", i, count, read_valid, read_data, write_ready); end
    end
    read_request = 0;
  endtask

  task automatic test_fill();
    write_request = 1;
    for (int i = 0; i < 4; i++) begin
      write_data = 32'hA0 + i;
      step();
      checks++; if (count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, i + 1); end
    end
    checks++; if (write_ready !== 1'b0) begin failures++; $display("FAIL full_write_ready got=%0b exp=0", write_ready); end
    write_data = 32'hA4;
    step();
    write_request = 0;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL drop_count got=%0d exp=4", count); end
    read_request = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (read_data !== 32'hA0 + i) begin failures++; $display("FAIL fill_pop got=%0h exp=%0h", read_data, 32'hA0 + i); end
      step();
    end
    read_request = 0;
    checks++; if (read_valid !== 1'b0 || read_data !== 32'h0) begin failures++; $display("FAIL fill_empty got rv=%0b rd=%0h exp 0/0", read_valid, read_data); end
  endtask

  task automatic test_full_rw();
    write_request = 1;
    for (int i = 0; i < 4; i++) begin
      write_data = 32'hA0 + i;
      step();
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_rw_pre_count got=%0d exp=4", count); end
    read_request = 1;
    write_data = 32'hA4;
    step();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_rw_count got=%0d exp=3", count); end
    checks++; if (read_data !== 32'hA1) begin failures++; $display("FAIL full_rw_head got=%0h exp=a1", read_data); end
    write_data = 32'hB0;
    step();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL both_fire_count got=%0d exp=3", count); end
    write_request = 0;
    checks++; if (read_data !== 32'hA2) begin failures++; $display("FAIL both_pop0 got=%0h exp=a2", read_data); end
    step();
    checks++; if (read_data !== 32'hA3) begin failures++; $display("FAIL both_pop1 got=%0h exp=a3", read_data); end
    step();
    checks++; if (read_data !== 32'hB0) begin failures++; $display("FAIL both_pop2 got=%0h exp=b0", read_data); end
    step();
    read_request = 0;
    checks++; if (count !== 3'd0 || read_valid !== 1'b0) begin failures++; $display("FAIL full_rw_drain got count=%0d rv=%0b exp 0/0", count, read_valid); end
  endtask

  task automatic test_empty_rw();
    write_data = 32'h55;
    write_request = 1;
    read_request = 1;
    step();
    write_request = 0;
    read_request = 0;
    checks++; if (read_valid !== 1'b1 || read_data !== 32'h55) begin failures++; $display("FAIL empty_rw got rv=%0b rd=%0h exp 1/55", read_valid, read_data); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL empty_rw_count got=%0d exp=1", count); end
    read_request = 1;
    step();
    read_request = 0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_rw_pop got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    write_data = 32'h0;
    write_request = 1;
    step();
    read_request = 1;
    for (int i = 1; i < 10; i++) begin
      write_data = i;
      checks++; if (read_data !== 32'(i - 1)) begin failures++; $display("FAIL stream_data got=%0h exp=%0h", read_data, i - 1); end
      step();
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL stream_count got=%0d exp=1", count); end
    end
    write_request = 0;
    checks++; if (read_data !== 32'h9) begin failures++; $display("FAIL stream_last got=%0h exp=9", read_data); end
    step();
    read_request = 0;
    checks++; if (count !== 3'd0 || read_data !== 32'h0) begin failures++; $display("FAIL stream_end got count=%0d rd=%0h exp 0/0", count, read_data); end
  endtask

  task automatic test_reset_mid();
    write_request = 1;
    for (int i = 0; i < 3; i++) begin
      write_data = 32'hC0 + i;
      step();
    end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
    reset = 1;
    write_data = 32'hCC;
    step();
    reset = 0;
    write_request = 0;
    checks++; if (count !== 3'd0 || read_valid !== 1'b0 || read_data !== 32'h0) begin failures++; $display("FAIL mid_reset got count=%0d rv=%0b rd=%0h exp 0/0/0", count, read_valid, read_data); end
    write_data = 32'hDD;
    write_request = 1;
    step();
    write_request = 0;
    checks++; if (count !== 3'd1 || read_data !== 32'hDD) begin failures++; $display("FAIL mid_after got count=%0d rd=%0h exp 1/dd", count, read_data); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_rw();
    test_empty_rw();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
